// File: rtl/bus_map_pkg.sv
// Address map, register targets and STATUS bit positions shared by the
// data-port responder and its bench.
package bus_map_pkg;

    localparam logic [31:0] GPIO_ADDR   = 32'h0000_1000;
    localparam logic [31:0] CYCLE_ADDR  = 32'h0000_1004;
    localparam logic [31:0] TIMER_ADDR  = 32'h0000_1008;
    localparam logic [31:0] STATUS_ADDR = 32'h0000_100C;

    localparam int STATUS_TIMER_BIT = 0;
    localparam int STATUS_FAULT_BIT = 1;
    localparam int STATUS_W         = 2;

    typedef enum logic [2:0] {
        TGT_RAM,
        TGT_GPIO,
        TGT_CYCLE,
        TGT_TIMER,
        TGT_STATUS,
        TGT_NONE
    } target_e;

    // Register decode ignores the byte offset so misaligned loads still hit.
    function automatic target_e decode_reg(input logic [31:0] addr);
        logic [31:0] word;
        word = {addr[31:2], 2'b00};
        if (word == GPIO_ADDR)        return TGT_GPIO;
        else if (word == CYCLE_ADDR)  return TGT_CYCLE;
        else if (word == TIMER_ADDR)  return TGT_TIMER;
        else if (word == STATUS_ADDR) return TGT_STATUS;
        else                          return TGT_NONE;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Loadable 32-bit down-counter; expire pulses on the cycle the count steps
// from 1 to 0 (a same-cycle load suppresses it).
module bus_timer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    output logic [31:0] count,
    output logic        expire
);

    logic [31:0] count_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (count_q != 32'd0) begin
            count_q <= count_q - 32'd1;
        end
    end

    assign count  = count_q;
    assign expire = reset && !load && (count_q == 32'd1);

endmodule

// File: rtl/data_bus_responder.sv
// Data-port responder for a single-cycle datapath: word RAM plus GPIO, cycle
// counter, countdown timer and sticky STATUS; loads are combinational.
module data_bus_responder
    import bus_map_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int GPIO_W      = 8
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              MemWrite,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic [GPIO_W-1:0] GPIO,
    output logic              TimerIrq,
    output logic              Fault
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]         mem [DEPTH_WORDS];
    logic [GPIO_W-1:0]   gpio_q;
    logic [31:0]         cycle_q;
    logic [STATUS_W-1:0] status_q;
    logic [STATUS_W-1:0] status_set;
    logic [STATUS_W-1:0] status_clr;
    logic [STATUS_W-1:0] status_d;
    logic [31:0]         timer_count;
    logic                timer_expire;
    logic                timer_load;
    target_e             tgt;
    logic                aligned;
    logic                store_ok;
    logic                fault_store;

    always_comb begin
        if (Addr[31:AW+2] == '0) tgt = TGT_RAM;
        else                     tgt = decode_reg(Addr);
    end

    // A store commits only when word-aligned and mapped; anything else is
    // swallowed and recorded as a fault.
    assign aligned     = (Addr[1:0] == 2'b00);
    assign store_ok    = MemWrite && aligned && (tgt != TGT_NONE);
    assign fault_store = MemWrite && !store_ok;
    assign timer_load  = store_ok && (tgt == TGT_TIMER);

    bus_timer u_timer (
        .clk        (CLK),
        .reset      (reset),
        .load       (timer_load),
        .load_value (WriteData),
        .count      (timer_count),
        .expire     (timer_expire)
    );

    always_ff @(posedge CLK) begin
        if (store_ok && (tgt == TGT_RAM)) begin
            mem[Addr[AW+1:2]] <= WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            gpio_q  <= '0;
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (store_ok && (tgt == TGT_GPIO)) begin
                gpio_q <= WriteData[GPIO_W-1:0];
            end
        end
    end

    // Sets are ORed after the W1C mask so a same-cycle set always wins.
    always_comb begin
        status_clr = '0;
        status_set = '0;
        if (store_ok && (tgt == TGT_STATUS)) begin
            status_clr = WriteData[STATUS_W-1:0];
        end
        status_set[STATUS_TIMER_BIT] = timer_expire;
        status_set[STATUS_FAULT_BIT] = fault_store;
        status_d = (status_q & ~status_clr) | status_set;
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    always_comb begin
        ReadData = '0;
        case (tgt)
            TGT_RAM:    ReadData = mem[Addr[AW+1:2]];
            TGT_GPIO:   ReadData = 32'(gpio_q);
            TGT_CYCLE:  ReadData = cycle_q;
            TGT_TIMER:  ReadData = timer_count;
            TGT_STATUS: ReadData = 32'(status_q);
            default:    ReadData = '0;
        endcase
    end

    assign GPIO     = gpio_q;
    assign TimerIrq = status_q[STATUS_TIMER_BIT];
    assign Fault    = status_q[STATUS_FAULT_BIT];

endmodule

// File: tb/tb_data_bus_responder.sv
// Directed bench for data_bus_responder: one task per feature, inline checks
// against hand-computed values, single summary line at the end.
module tb_data_bus_responder;

    logic        CLK = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  GPIO;
    logic        TimerIrq;
    logic        Fault;

    int cmp_count  = 0;
    int fail_count = 0;

    data_bus_responder #(.DEPTH_WORDS(64), .GPIO_W(8)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .GPIO      (GPIO),
        .TimerIrq  (TimerIrq),
        .Fault     (Fault)
    );

    always #5 CLK = ~CLK;

    // Drives a store in the current low phase; returns at the next negedge.
    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        Addr      = a;
        WriteData = d;
        MemWrite  = 1'b1;
        @(negedge CLK);
        MemWrite  = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        MemWrite = 1'b0;
        Addr     = a;
        #1;
        d = ReadData;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        reset = 1'b0; MemWrite = 1'b0; Addr = '0; WriteData = '0;
        idle(2);
        reset = 1'b1;
        idle(3);
        do_read(32'h1004, d);
        cmp_count++;
        if (d !== 32'd3) begin fail_count++; $display("FAIL reset_cycle got=%h exp=%h", d, 32'd3); end
        cmp_count++;
        if (GPIO !== 8'h00) begin fail_count++; $display("FAIL reset_gpio got=%h exp=00", GPIO); end
        do_read(32'h100C, d);
        cmp_count++;
        if (d !== 32'd0) begin fail_count++; $display("FAIL reset_status got=%h exp=0", d); end
        cmp_count++;
        if ({TimerIrq, Fault} !== 2'b00) begin fail_count++; $display("FAIL reset_irq_fault got=%b exp=00", {TimerIrq, Fault}); end
    endtask

    task automatic test_ram;
        logic [31:0] d;
        @(negedge CLK);
        do_store(32'h10, 32'hDEADBEEF);
        do_read(32'h10, d);
        cmp_count++;
        if (d !== 32'hDEADBEEF) begin fail_count++; $display("FAIL ram_load got=%h exp=deadbeef", d); end
        do_read(32'h13, d);
        cmp_count++;
        if (d !== 32'hDEADBEEF) begin fail_count++; $display("FAIL ram_misaligned_load got=%h exp=deadbeef", d); end
        // Load of the address being stored in the same cycle sees the old word.
        @(negedge CLK);
        Addr = 32'h10; WriteData = 32'h0BAD_F00D; MemWrite = 1'b1;
        #1;
        d = ReadData;
        cmp_count++;
        if (d !== 32'hDEADBEEF) begin fail_count++; $display("FAIL ram_store_cycle_old got=%h exp=deadbeef", d); end
        @(negedge CLK);
        MemWrite = 1'b0;
        do_read(32'h10, d);
        cmp_count++;
        if (d !== 32'h0BADF00D) begin fail_count++; $display("FAIL ram_overwrite got=%h exp=0badf00d", d); end
        do_read(32'h2000, d);
        cmp_count++;
        if (d !== 32'd0) begin fail_count++; $display("FAIL unmapped_load got=%h exp=0", d); end
        cmp_count++;
        if (Fault !== 1'b0) begin fail_count++; $display("FAIL unmapped_load_fault got=%b exp=0", Fault); end
    endtask

    task automatic test_gpio_fault;
        logic [31:0] d;
        @(negedge CLK);
        do_store(32'h0, 32'h1122_3344);
        do_store(32'h1000, 32'h1FF);
        cmp_count++;
        if (GPIO !== 8'hFF) begin fail_count++; $display("FAIL gpio_out got=%h exp=ff", GPIO); end
        do_read(32'h1000, d);
        cmp_count++;
        if (d !== 32'h0000_00FF) begin fail_count++; $display("FAIL gpio_read got=%h exp=000000ff", d); end
        @(negedge CLK);
        do_store(32'h2, 32'hAAAA_5555);
        do_read(32'h0, d);
        cmp_count++;
        if (d !== 32'h1122_3344) begin fail_count++; $display("FAIL fault_ram_kept got=%h exp=11223344", d); end
        cmp_count++;
        if (Fault !== 1'b1) begin fail_count++; $display("FAIL fault_set got=%b exp=1", Fault); end
        // Misaligned W1C to STATUS is itself a fault store: bit1 stays set.
        @(negedge CLK);
        do_store(32'h100D, 32'h3);
        cmp_count++;
        if (Fault !== 1'b1) begin fail_count++; $display("FAIL fault_status_set_wins got=%b exp=1", Fault); end
        do_store(32'h100C, 32'h2);
        cmp_count++;
        if (Fault !== 1'b0) begin fail_count++; $display("FAIL fault_clear got=%b exp=0", Fault); end
        do_store(32'h1004, 32'h1234);
        do_read(32'h1004, d);
        cmp_count++;
        if (Fault !== 1'b0) begin fail_count++; $display("FAIL cycle_write_no_fault got=%b exp=0", Fault); end
        cmp_count++;
        if (d === 32'h1234) begin fail_count++; $display("FAIL cycle_write_ignored got=%h exp=not 00001234", d); end
        @(negedge CLK);
        do_store(32'h2000, 32'h1);
        cmp_count++;
        if (Fault !== 1'b1) begin fail_count++; $display("FAIL unmapped_store_fault got=%b exp=1", Fault); end
        do_store(32'h1000, 32'h0);
        cmp_count++;
        if (GPIO !== 8'h00) begin fail_count++; $display("FAIL gpio_clear got=%h exp=00", GPIO); end
        do_store(32'h100C, 32'h2);
        cmp_count++;
        if (Fault !== 1'b0) begin fail_count++; $display("FAIL fault_clear2 got=%b exp=0", Fault); end
    endtask

    task automatic test_timer;
        logic [31:0] d;
        logic [31:0] exp_cnt;
        @(negedge CLK);
        do_store(32'h1008, 32'd5);
        for (int i = 4; i >= 0; i--) begin
            @(negedge CLK);
            do_read(32'h1008, d);
            exp_cnt = 32'(i);
            cmp_count++;
            if (d !== exp_cnt) begin fail_count++; $display("FAIL timer_count got=%h exp=%h", d, exp_cnt); end
            cmp_count++;
            if (TimerIrq !== (i == 0)) begin fail_count++; $display("FAIL timer_irq step=%0d got=%b exp=%b", i, TimerIrq, (i == 0)); end
        end
        idle(2);
        cmp_count++;
        if (TimerIrq !== 1'b1) begin fail_count++; $display("FAIL timer_irq_sticky got=%b exp=1", TimerIrq); end
        do_store(32'h100C, 32'h1);
        cmp_count++;
        if (TimerIrq !== 1'b0) begin fail_count++; $display("FAIL timer_irq_clear got=%b exp=0", TimerIrq); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] d;
        @(negedge CLK);
        do_store(32'h1008, 32'd1);
        do_store(32'h100C, 32'h1);
        cmp_count++;
        if (TimerIrq !== 1'b1) begin fail_count++; $display("FAIL expire_vs_w1c got=%b exp=1", TimerIrq); end
        do_store(32'h100C, 32'h1);
        do_store(32'h1008, 32'd1);
        do_store(32'h1008, 32'd7);
        do_read(32'h1008, d);
        cmp_count++;
        if (d !== 32'd7) begin fail_count++; $display("FAIL reload_wins_count got=%h exp=7", d); end
        cmp_count++;
        if (TimerIrq !== 1'b0) begin fail_count++; $display("FAIL reload_wins_irq got=%b exp=0", TimerIrq); end
        @(negedge CLK);
        do_store(32'h1008, 32'd0);
        idle(9);
        do_read(32'h1008, d);
        cmp_count++;
        if ({d, TimerIrq} !== 33'd0) begin fail_count++; $display("FAIL timer_stop got=%h/%b exp=0/0", d, TimerIrq); end
    endtask

    task automatic test_wrap_and_reset;
        logic [31:0] d;
        @(negedge CLK);
        dut.cycle_q = 32'hFFFF_FFFE;
        @(negedge CLK);
        do_read(32'h1004, d);
        cmp_count++;
        if (d !== 32'hFFFF_FFFF) begin fail_count++; $display("FAIL cycle_pre_wrap got=%h exp=ffffffff", d); end
        @(negedge CLK);
        do_read(32'h1004, d);
        cmp_count++;
        if (d !== 32'h0) begin fail_count++; $display("FAIL cycle_wrap got=%h exp=0", d); end
        @(negedge CLK);
        do_store(32'h1008, 32'd4);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        do_read(32'h1008, d);
        cmp_count++;
        if (d !== 32'd0) begin fail_count++; $display("FAIL reset_timer got=%h exp=0", d); end
        do_read(32'h1004, d);
        cmp_count++;
        if (d !== 32'd0) begin fail_count++; $display("FAIL reset_cycle_hold got=%h exp=0", d); end
        idle(6);
        cmp_count++;
        if (TimerIrq !== 1'b0) begin fail_count++; $display("FAIL reset_no_expire got=%b exp=0", TimerIrq); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_gpio_fault();
        test_timer();
        test_back_to_back();
        test_wrap_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
